// File: rtl/calc_op_sequencer.sv
// Sequences one ALU operation at a time, packs the result word and queues it in a show-ahead FIFO.
// Optional EXEC watchdog enabled by defining CALC_TIMEOUT_EN.
module calc_op_sequencer #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [7:0]               req_a,
    input  logic [7:0]               req_b,
    input  logic [3:0]               req_op,
    output logic                     alu_start,
    output logic [7:0]               alu_a,
    output logic [7:0]               alu_b,
    output logic [3:0]               alu_op,
    input  logic                     alu_done,
    input  logic [7:0]               alu_result,
    input  logic [3:0]               alu_flags,
    output logic [7:0]               cat_a,
    output logic [7:0]               cat_b,
    output logic [7:0]               cat_c,
    output logic [3:0]               cat_d,
    output logic [3:0]               cat_e,
    input  logic [31:0]              cat_dout,
    input  logic                     rd_en,
    output logic [31:0]              rd_data,
    output logic                     rd_valid,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     busy
);
    localparam int unsigned AW = $clog2(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_param_check
        $error("calc_op_sequencer: DEPTH must be a power of 2 >= 2 and TIMEOUT >= 1");
    end

    typedef enum logic [1:0] {StIdle, StExec, StPack} state_e;

    state_e      state_q;
    logic [7:0]  a_q, b_q, res_q;
    logic [3:0]  op_q, flags_q;
    logic        start_q;

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;

    logic accept, wr_en, rd_pop;

`ifdef CALC_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tmo_q;
`endif

    assign full      = (count_q == (AW + 1)'(DEPTH));
    assign rd_valid  = (count_q != '0);
    assign req_ready = (state_q == StIdle) && !full;
    assign busy      = (state_q != StIdle);
    assign accept    = req_valid && req_ready;
    // PACK is only ever entered with a free slot, since accept required !full.
    assign wr_en     = (state_q == StPack);
    assign rd_pop    = rd_en && rd_valid;

    assign alu_start = start_q;
    assign alu_a     = a_q;
    assign alu_b     = b_q;
    assign alu_op    = op_q;
    assign cat_a     = a_q;
    assign cat_b     = b_q;
    assign cat_c     = res_q;
    assign cat_d     = op_q;
    assign cat_e     = flags_q;
    assign count     = count_q;
    assign rd_data   = rd_valid ? mem[rd_ptr_q] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            res_q   <= '0;
            flags_q <= '0;
            start_q <= 1'b0;
`ifdef CALC_TIMEOUT_EN
            tmo_q   <= '0;
`endif
        end else begin
            start_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (accept) begin
                        a_q     <= req_a;
                        b_q     <= req_b;
                        op_q    <= req_op;
                        start_q <= 1'b1;
                        state_q <= StExec;
`ifdef CALC_TIMEOUT_EN
                        tmo_q   <= '0;
`endif
                    end
                end
                StExec: begin
                    // A done on the final watchdog cycle takes priority over the error word.
                    if (alu_done) begin
                        res_q   <= alu_result;
                        flags_q <= alu_flags;
                        state_q <= StPack;
                    end
`ifdef CALC_TIMEOUT_EN
                    else if (tmo_q == TW'(TIMEOUT - 1)) begin
                        res_q   <= 8'h00;
                        flags_q <= 4'hF;
                        state_q <= StPack;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
`endif
                end
                StPack:  state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en)  wr_ptr_q <= wr_ptr_q + 1'b1;
            if (rd_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            if (wr_en && !rd_pop)      count_q <= count_q + 1'b1;
            else if (!wr_en && rd_pop) count_q <= count_q - 1'b1;
        end
    end

    // Storage carries no reset; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr_q] <= cat_dout;
    end

endmodule

// File: tb/tb_calc_op_sequencer.sv
// Directed bench for calc_op_sequencer; the packer is modelled as a plain concatenation.
// Also exercises the watchdog path when CALC_TIMEOUT_EN is defined.
module tb_calc_op_sequencer;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready;
    logic [7:0]  req_a, req_b;
    logic [3:0]  req_op;
    logic        alu_start;
    logic [7:0]  alu_a, alu_b;
    logic [3:0]  alu_op;
    logic        alu_done;
    logic [7:0]  alu_result;
    logic [3:0]  alu_flags;
    logic [7:0]  cat_a, cat_b, cat_c;
    logic [3:0]  cat_d, cat_e;
    logic [31:0] cat_dout;
    logic        rd_en;
    logic [31:0] rd_data;
    logic        rd_valid, full, busy;
    logic [2:0]  count;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_w [4];

    always #5 clk = ~clk;

    assign cat_dout = {cat_a, cat_b, cat_c, cat_d, cat_e};

    calc_op_sequencer #(.DEPTH(4), .TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .alu_start(alu_start), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_done(alu_done), .alu_result(alu_result), .alu_flags(alu_flags),
        .cat_a(cat_a), .cat_b(cat_b), .cat_c(cat_c), .cat_d(cat_d), .cat_e(cat_e),
        .cat_dout(cat_dout),
        .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
        .full(full), .count(count), .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Runs one operation; the ALU answers after d extra EXEC cycles.
    task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op,
                         input logic [7:0] res, input logic [3:0] fl, input int d);
        req_valid = 1'b1; req_a = a; req_b = b; req_op = op;
        @(negedge clk);
        req_valid = 1'b0;
        chk("op_start", {31'd0, alu_start}, 32'd1);
        chk("op_alu_ab", {16'd0, alu_a, alu_b}, {16'd0, a, b});
        chk("op_alu_op", {28'd0, alu_op}, {28'd0, op});
        for (int i = 0; i < d; i++) begin
            @(negedge clk);
            chk("op_start_once", {31'd0, alu_start}, 32'd0);
            chk("op_busy_exec", {31'd0, busy}, 32'd1);
        end
        alu_done = 1'b1; alu_result = res; alu_flags = fl;
        @(negedge clk);
        alu_done = 1'b0;
        chk("op_pack_word", cat_dout, {a, b, res, op, fl});
        @(negedge clk);
        chk("op_idle", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_a = '0; req_b = '0; req_op = '0;
        alu_done = 1'b0; alu_result = '0; alu_flags = '0; rd_en = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
        chk("rst_count", {29'd0, count}, 32'd0);
        chk("rst_alu_start", {31'd0, alu_start}, 32'd0);
        chk("rst_rd_data", rd_data, 32'd0);
        chk("rst_full", {31'd0, full}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_req_ready", {31'd0, req_ready}, 32'd1);

        // Two operations then drain
        do_op(8'h10, 8'h02, 4'h7, 8'h12, 4'h9, 3);
        chk("op1_rd_data", rd_data, 32'h10021279);
        chk("op1_count", {29'd0, count}, 32'd1);
        do_op(8'h14, 8'h13, 4'h4, 8'h10, 4'h7, 1);
        chk("op2_count", {29'd0, count}, 32'd2);
        chk("pop1_data", rd_data, 32'h10021279);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        chk("pop2_data", rd_data, 32'h14131047);
        chk("pop2_count", {29'd0, count}, 32'd1);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        chk("drain_valid", {31'd0, rd_valid}, 32'd0);
        chk("drain_data", rd_data, 32'd0);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        chk("empty_pop_count", {29'd0, count}, 32'd0);

        // Fill to full across the pointer wrap
        exp_w[0] = 32'h40506018;
        exp_w[1] = 32'h41516129;
        exp_w[2] = 32'h4252623A;
        exp_w[3] = 32'h4353634B;
        do_op(8'h40, 8'h50, 4'h1, 8'h60, 4'h8, 0);
        chk("lat_rd_valid", {31'd0, rd_valid}, 32'd1);
        do_op(8'h41, 8'h51, 4'h2, 8'h61, 4'h9, 0);
        do_op(8'h42, 8'h52, 4'h3, 8'h62, 4'hA, 0);
        do_op(8'h43, 8'h53, 4'h4, 8'h63, 4'hB, 2);
        chk("full_flag", {31'd0, full}, 32'd1);
        chk("full_count", {29'd0, count}, 32'd4);
        chk("full_ready", {31'd0, req_ready}, 32'd0);
        req_valid = 1'b1; req_a = 8'hAA; req_b = 8'hBB; req_op = 4'hC;
        repeat (3) begin
            @(negedge clk);
            chk("full_hold_busy", {31'd0, busy}, 32'd0);
        end
        chk("wrap_head0", rd_data, exp_w[0]);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        chk("pop_full_clr", {31'd0, full}, 32'd0);
        chk("pop_ready", {31'd0, req_ready}, 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        chk("fifth_start", {31'd0, alu_start}, 32'd1);
        chk("fifth_alu_a", {24'd0, alu_a}, 32'h000000AA);
        alu_done = 1'b1; alu_result = 8'hCC; alu_flags = 4'hD;
        @(negedge clk);
        alu_done = 1'b0;
        @(negedge clk);
        chk("fifth_count", {29'd0, count}, 32'd4);
        for (int i = 1; i < 4; i++) begin
            chk("wrap_order", rd_data, exp_w[i]);
            rd_en = 1'b1;
            @(negedge clk);
            rd_en = 1'b0;
        end
        chk("wrap_fifth", rd_data, 32'hAABBCCCD);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        chk("wrap_empty", {31'd0, rd_valid}, 32'd0);

        // Reset while an operation is in EXEC
        do_op(8'h01, 8'h02, 4'h3, 8'h04, 4'h5, 0);
        req_valid = 1'b1; req_a = 8'h77; req_b = 8'h66; req_op = 4'h5;
        @(negedge clk);
        req_valid = 1'b0;
        chk("mid_busy", {31'd0, busy}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_count", {29'd0, count}, 32'd0);
        chk("mid_rst_valid", {31'd0, rd_valid}, 32'd0);
        chk("mid_rst_alu_a", {24'd0, alu_a}, 32'd0);
        chk("mid_rst_cat", cat_dout, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        alu_done = 1'b1; alu_result = 8'hEE; alu_flags = 4'h1;
        @(negedge clk);
        alu_done = 1'b0;
        @(negedge clk);
        chk("late_done_count", {29'd0, count}, 32'd0);
        chk("late_done_busy", {31'd0, busy}, 32'd0);

        // EXEC with no alu_done
        req_valid = 1'b1; req_a = 8'h05; req_b = 8'h03; req_op = 4'h2;
        @(negedge clk);
        req_valid = 1'b0;
`ifdef CALC_TIMEOUT_EN
        repeat (15) @(negedge clk);
        chk("tmo_still_exec", {31'd0, busy}, 32'd1);
        chk("tmo_no_word", {31'd0, rd_valid}, 32'd0);
        @(negedge clk);
        chk("tmo_pack_word", cat_dout, 32'h0503002F);
        chk("tmo_pack_nowrite", {31'd0, rd_valid}, 32'd0);
        @(negedge clk);
        chk("tmo_busy", {31'd0, busy}, 32'd0);
        chk("tmo_ready", {31'd0, req_ready}, 32'd1);
        chk("tmo_rd_data", rd_data, 32'h0503002F);
        alu_done = 1'b1; alu_result = 8'h99; alu_flags = 4'h3;
        @(negedge clk);
        alu_done = 1'b0;
        @(negedge clk);
        chk("tmo_late_done", {29'd0, count}, 32'd1);
`else
        repeat (40) @(negedge clk);
        chk("wait_busy", {31'd0, busy}, 32'd1);
        chk("wait_no_word", {31'd0, rd_valid}, 32'd0);
        alu_done = 1'b1; alu_result = 8'h08; alu_flags = 4'h1;
        @(negedge clk);
        alu_done = 1'b0;
        @(negedge clk);
        chk("wait_rd_data", rd_data, 32'h05030821);
        chk("wait_ready", {31'd0, req_ready}, 32'd1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/calc_op_sequencer.md
Name: calc_op_sequencer

Overview:
- Controller that sequences one calculator operation at a time through an external ALU and the 32-bit result-word packer (concatenator).
- Accepts an operand/opcode request and issues a one-cycle start pulse to the ALU, then waits for the ALU's done signal.
- Drives the packer with {A, B, result, opcode, flags} and pushes the packed word into an internal result FIFO, which the downstream reader drains.

Parameters:
- DEPTH, 4, number of entries in the result FIFO; must be a power of 2 and at least 2.
- TIMEOUT, 16, maximum number of EXEC cycles spent waiting for alu_done; used only with CALC_TIMEOUT_EN.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  sequencer can accept a request.
- req_a  in  8  operand A.
- req_b  in  8  operand B.
- req_op  in  4  opcode.
- alu_start  out  1  one-cycle ALU start pulse.
- alu_a  out  8  registered operand A.
- alu_b  out  8  registered operand B.
- alu_op  out  4  registered opcode.
- alu_done  in  1  ALU result valid; sampled only in EXEC.
- alu_result  in  8  ALU result.
- alu_flags  in  4  ALU flags.
- cat_a  out  8  packer field [31:24], operand A.
- cat_b  out  8  packer field [23:16], operand B.
- cat_c  out  8  packer field [15:8], result.
- cat_d  out  4  packer field [7:4], opcode.
- cat_e  out  4  packer field [3:0], flags.
- cat_dout  in  32  packed word returned by the packer (combinational).
- rd_en  in  1  pop the FIFO head.
- rd_data  out  32  FIFO head word, show-ahead.
- rd_valid  out  1  FIFO not empty.
- full  out  1  FIFO full.
- count  out  $clog2(DEPTH)+1  FIFO occupancy.
- busy  out  1  state is not IDLE.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE.
  - All holding registers, FIFO pointers and count cleared; FIFO contents undefined.
  - Outputs: alu_start=0, alu_a/alu_b/alu_op=0, all cat_* fields=0, rd_valid=0, full=0, count=0, busy=0.
  - rd_data=0 while the FIFO is empty.
  - req_ready=1 after reset release.
- Reset mid-operation: the operation in flight is discarded and no word is written. An alu_done arriving after reset is ignored.
- req_ready = (state==IDLE) && !full.
- Accept: req_valid && req_ready at an edge.
  - Captures A, B and op into the holding registers.
  - Moves to EXEC.
- EXEC:
  - alu_start=1 only in the first EXEC cycle.
  - alu_a, alu_b and alu_op are held stable throughout EXEC.
  - On alu_done=1 at an edge (including the first EXEC cycle): capture alu_result and alu_flags, move to PACK.
- PACK (one cycle):
  - cat_* are driven from the holding registers.
  - At the closing edge, cat_dout is written to the FIFO tail and the state returns to IDLE.
- Latency: minimum accept edge to rd_valid=1 is 3 edges, when alu_done=1 in the first EXEC cycle.
- Only one operation is ever in flight. Because accept requires !full, the write in PACK always has a free slot.
- FIFO:
  - rd_en && rd_valid pops the head; rd_data updates to the next entry after the edge.
  - rd_en while empty is ignored.
  - Write and pop on the same edge: both occur, count is unchanged.
  - Pointers wrap modulo DEPTH.
  - full = (count==DEPTH).
- alu_done outside EXEC is ignored.

Optional Feature:
- Macro: CALC_TIMEOUT_EN.
- With the macro defined:
  - An EXEC cycle counter clears on entry to EXEC.
  - If TIMEOUT cycles elapse without alu_done, move to PACK with result=8'h00 and flags=4'hF (error word).
  - alu_done arriving on the timeout cycle wins over the timeout.
  - A late alu_done received in IDLE is ignored.
- Without the macro: EXEC waits indefinitely for alu_done and there is no counter logic.

Test Plan:
- Reset, then release → req_ready=1, busy=0, rd_valid=0, count=0, alu_start=0.
- A=0x10, B=0x02, op=0x7; ALU returns result 0x12, flags 0x9 after 3 cycles → exactly one alu_start pulse with alu_a=0x10, alu_b=0x02; rd_data=0x10021279, count=1.
- Follow with A=0x14, B=0x13, op=0x4; result 0x10, flags 0x7 → two rd_en pops return 0x10021279 then 0x14131047, then rd_valid=0.
- Four operations with no reads → full=1, count=4, req_ready=0; a fifth req_valid is held and not accepted. One rd_en → full=0 next cycle and the fifth request is accepted; the word order is preserved across pointer wrap.
- Assert rst_n=0 mid-EXEC with one word already in the FIFO → outputs reset immediately, count=0; a later alu_done pulse causes no write.
- CALC_TIMEOUT_EN defined, A=0x05, B=0x03, op=0x2, no alu_done for 16 cycles → word 0x050300 2F written; busy drops and req_ready=1 after PACK.
